// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction width, opcode constants and
// the boot-time instruction-memory loader state encoding.
package processor_pkg;

  // Instruction word width used by the fetch path and the boot loader.
  localparam int INSTR_W = 32;

  // RV32I major opcodes decoded by the control unit.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Boot loader states: two count bytes, word collection, one write
  // cycle per word, then a terminal done or error state.
  typedef enum logic [2:0] {
    S_LEN0    = 3'd0,
    S_LEN1    = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: gathers four stream bytes into one 32-bit
// word. Only the first three bytes are stored; the fourth byte is passed
// straight through into bits [31:24] on the cycle it arrives, which is the
// cycle word_ready_o is high and the word must be captured.
module byte_packer
  import processor_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_ready_o,
  output logic [1:0]         byte_idx_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] lanes_q, lanes_d;

  // Lane insert and byte index advance; a stalled source leaves both alone.
  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (clear_i) begin
      byte_idx_d = 2'd0;
    end else if (byte_valid_i) begin
      case (byte_idx_q)
        2'd0:    lanes_d[7:0]   = byte_data_i;
        2'd1:    lanes_d[15:8]  = byte_data_i;
        2'd2:    lanes_d[23:16] = byte_data_i;
        default: lanes_d        = lanes_q;
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q <= 2'd0;
      lanes_q    <= 24'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

  assign word_o       = {byte_data_i, lanes_q};
  assign word_ready_o = byte_valid_i && (byte_idx_q == 2'd3);
  assign byte_idx_o   = byte_idx_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Accepts a 16-bit word count and
// then that many little-endian words over a valid/ready byte stream,
// writes each word to instruction memory, and holds the processor until
// the whole image is in place.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready;
// in_ready depends on state only (never on in_valid), and the source must
// keep in_data stable while in_valid is high and in_ready is low.
module imem_loader
  import processor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               IMemWrite,
  output logic [31:0]        IMemAddr,
  output logic [INSTR_W-1:0] IMemData,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output loader_state_e      dbg_state
);

  loader_state_e      state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        word_idx_q, word_idx_d;
  logic [31:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;

  logic               xfer;
  logic               pack_clear;
  logic               pack_valid;
  logic [INSTR_W-1:0] pack_word;
  logic               pack_ready;
  logic [1:0]         pack_idx;
  logic [15:0]        full_count;
  logic [15:0]        word_idx_inc;

  assign xfer         = in_valid && in_ready;
  assign full_count   = {in_data, count_q[7:0]};
  assign word_idx_inc = word_idx_q + 16'd1;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_data_i  (in_data),
    .word_o       (pack_word),
    .word_ready_o (pack_ready),
    .byte_idx_o   (pack_idx)
  );

  // Next-state, counters and Moore outputs of the loader FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pack_clear = 1'b0;
    pack_valid = 1'b0;
    in_ready   = 1'b0;
    IMemWrite  = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state_q)
      S_LEN0: begin
        in_ready = 1'b1;
        if (xfer) begin
          count_d[7:0] = in_data;
          state_d      = S_LEN1;
        end
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (xfer) begin
          count_d[15:8] = in_data;
          if (full_count == 16'd0) begin
            state_d = S_DONE;
          end else if (full_count > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_COLLECT;
            word_idx_d = 16'd0;
            pack_clear = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        in_ready   = 1'b1;
        pack_valid = xfer;
        if (pack_ready) begin
          data_d  = pack_word;
          addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        IMemWrite  = 1'b1;
        word_idx_d = word_idx_inc;
        pack_clear = 1'b1;
        if (word_idx_inc == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (restart) begin
          state_d    = S_LEN0;
          addr_d     = BASE_ADDR;
          count_d    = 16'd0;
          word_idx_d = 16'd0;
          pack_clear = 1'b1;
        end
      end
      S_ERR: begin
        load_err = 1'b1;
        if (restart) begin
          state_d    = S_LEN0;
          addr_d     = BASE_ADDR;
          count_d    = 16'd0;
          word_idx_d = 16'd0;
          pack_clear = 1'b1;
        end
      end
      default: begin
        state_d = S_LEN0;
      end
    endcase
  end

  // Loader state, counters and write-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LEN0;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign IMemAddr  = addr_q;
  assign IMemData  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte stream driver, write monitor with an
// expected-write queue, and a single summary line.
module tb_imem_loader;
  import processor_pkg::*;

  logic          clk;
  logic          reset;
  logic          restart;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          IMemWrite;
  logic [31:0]   IMemAddr;
  logic [31:0]   IMemData;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  loader_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .IMemWrite (IMemWrite),
    .IMemAddr  (IMemAddr),
    .IMemData  (IMemData),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: one entry per cycle with IMemWrite high.
  always @(negedge clk) begin
    if (!reset && IMemWrite) begin
      got_addr_q.push_back(IMemAddr);
      got_data_q.push_back(IMemData);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present one byte, wait (bounded) for acceptance, then drop valid.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 20;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high byte=%h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard: compare monitored writes against the expected queue.
  task automatic check_writes(input string tag);
    logic [31:0] ga, gd, ea, ed;
    check({tag, "_count"}, 32'(got_data_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_data_q.size() > 0) begin
      ga = got_addr_q.pop_front();
      gd = got_data_q.pop_front();
      ea = exp_addr_q.pop_front();
      ed = exp_q.pop_front();
      check({tag, "_addr"}, ga, ea);
      check({tag, "_data"}, gd, ed);
    end
    got_addr_q.delete();
    got_data_q.delete();
    exp_addr_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  initial begin
    reset    = 1'b1;
    restart  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(S_LEN0));
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(IMemWrite), 32'd0);
    check("rst_addr", IMemAddr, 32'h0);
    check("rst_data", IMemData, 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);

    // Two-word image, back-to-back bytes
    expect_write(32'h0, 32'h00A00513);
    expect_write(32'h4, 32'h00B50633);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h06); send_byte(8'hB5); send_byte(8'h00);
    @(negedge clk);
    check("t1_write2_we", 32'(IMemWrite), 32'd1);
    check("t1_write2_ready", 32'(in_ready), 32'd0);
    check("t1_hold_during_write", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_we_off", 32'(IMemWrite), 32'd0);
    check("t1_ready_done", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check_writes("t1");

    // Zero-word image
    pulse_restart();
    check("t2_hold_rearm", 32'(cpu_hold), 32'd1);
    check("t2_done_clear", 32'(load_done), 32'd0);
    check("t2_ready_rearm", 32'(in_ready), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd0);
    check_writes("t2");

    // Oversized count 257
    pulse_restart();
    send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_ready", 32'(in_ready), 32'd0);
    check("t3_done", 32'(load_done), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_err_sticky", 32'(load_err), 32'd1);
    check_writes("t3");
    pulse_restart();
    check("t3_err_clear", 32'(load_err), 32'd0);
    check("t3_ready_back", 32'(in_ready), 32'd1);

    // One word with a 3-cycle gap between bytes 2 and 3
    expect_write(32'h0, 32'h12345678);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    repeat (3) begin
      @(negedge clk);
      check("t4_gap_ready", 32'(in_ready), 32'd1);
      check("t4_gap_we", 32'(IMemWrite), 32'd0);
    end
    send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    check("t4_we", 32'(IMemWrite), 32'd1);
    check("t4_ready_write", 32'(in_ready), 32'd0);
    check("t4_data_live", IMemData, 32'h12345678);
    @(negedge clk);
    check("t4_done", 32'(load_done), 32'd1);
    check_writes("t4");

    // Reset in the middle of a word
    pulse_restart();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    check("t5_rst_state", 32'(dbg_state), 32'(S_LEN0));
    check("t5_rst_hold", 32'(cpu_hold), 32'd1);
    check("t5_rst_addr", IMemAddr, 32'h0);
    expect_write(32'h0, 32'hDEADBEEF);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    repeat (2) @(negedge clk);
    check("t5_done", 32'(load_done), 32'd1);
    check_writes("t5");

    // Restart after done, reload a single word
    pulse_restart();
    check("t6_hold_rearm", 32'(cpu_hold), 32'd1);
    check("t6_addr_rearm", IMemAddr, 32'h0);
    expect_write(32'h0, 32'h00100093);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    @(negedge clk);
    check("t6_hold_write", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_release", 32'(cpu_hold), 32'd0);
    check_writes("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
